adsr_log_env: RTL and testbench
===============================

ADSR_LOG_ENV -- requirements
Module: adsr_log_env

Interface
REQ-001 SHALL have parameter WIDTH, default 24, envelope/coefficient/base width in bits.
REQ-002 SHALL have parameter ATTACK_TARGET, default 2^WIDTH-1, the level that ends ATTACK.
REQ-003 SHALL have parameter DECAY_EPS, default 256, the tolerance above sustain_level that ends DECAY.
REQ-004 SHALL have parameter RELEASE_FLOOR, default 256, the level at or below which RELEASE ends.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port ce  input  1  sample tick; state/envelope advance only on clk edges with ce=1.
REQ-008 SHALL have port gate  input  1  note-on level.
REQ-009 SHALL have ports attack_coef, decay_coef, release_coef  input  WIDTH each  unsigned fractional multipliers (value/2^WIDTH).
REQ-010 SHALL have ports attack_base, decay_base, release_base  input  WIDTH each  unsigned per-step additive terms.
REQ-011 SHALL have port sustain_level  input  WIDTH  sustain hold level.
REQ-012 SHALL have port envelope  output  WIDTH  registered envelope value.
REQ-013 SHALL have port state  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
REQ-014 SHALL have port busy  output  1  high when state is not IDLE.
REQ-015 SHALL have port env_valid  output  1  one-cycle pulse on the cycle after each ce update.

Function
REQ-016 SHALL hold envelope and state unchanged on every edge with ce=0; all inputs are sampled only on ce edges.
REQ-017 SHALL compute, per step in ATTACK/DECAY/RELEASE, next = base + floor((envelope*coef)/2^WIDTH) using the 2*WIDTH-bit product and a WIDTH+1-bit sum, selecting the current phase's coef/base.
REQ-018 SHALL saturate next to 2^WIDTH-1 when the sum overflows WIDTH bits.
REQ-019 SHALL, in IDLE with gate=1 on ce, enter ATTACK and load envelope with the first ATTACK step; otherwise IDLE holds envelope at 0.
REQ-020 SHALL, in ATTACK, load next; if next >= ATTACK_TARGET, load ATTACK_TARGET and enter DECAY.
REQ-021 SHALL, in DECAY, load next; if next <= sustain_level + DECAY_EPS (WIDTH+1-bit compare), load sustain_level and enter SUSTAIN.
REQ-022 SHALL, in SUSTAIN, load sustain_level every ce, so live sustain_level changes track.
REQ-023 SHALL, in ATTACK, DECAY or SUSTAIN with gate=0 on ce, enter RELEASE and apply the first RELEASE step in that same ce.
REQ-024 SHALL, in RELEASE, load next; if next <= RELEASE_FLOOR, load 0 and enter IDLE.
REQ-025 SHALL, in RELEASE with gate=1 on ce, re-enter ATTACK without resetting envelope, applying an ATTACK step from the current value.
REQ-026 SHALL give gate transitions priority over threshold transitions when both occur on the same ce.
REQ-027 SHALL make envelope, state and busy visible one clk after the ce edge, i.e. one-cycle latency.
REQ-028 SHALL treat an out-of-range internal state encoding as IDLE with envelope forced to 0 on the next ce.

Reset
REQ-029 SHALL on rst=1 set envelope=0, state=IDLE, busy=0, env_valid=0, regardless of ce, gate or current phase.
REQ-030 SHALL give rst priority over ce, including mid-ATTACK/RELEASE; the first ce after rst deasserts behaves as IDLE.

Verification
REQ-031 SHALL verify: rst for 2 cycles during ATTACK -> envelope=0, state=0, busy=0 on the next cycle.
REQ-032 SHALL verify: WIDTH=24, attack_coef=16776829, attack_base=391, gate=1, two ce pulses from IDLE -> envelope=391 then 781, state=1, env_valid pulses twice.
REQ-033 SHALL verify: attack_base=0xFFFFFF, attack_coef=0x800000, one ce -> saturation, envelope=0xFFFFFF, state=2.
REQ-034 SHALL verify: in DECAY, decay_coef=0, decay_base=0x400000, sustain_level=0x400000, one ce -> envelope=0x400000, state=3; changing sustain_level to 0x200000 then one ce -> envelope=0x200000.
REQ-035 SHALL verify: gate=0 in SUSTAIN with release_coef=0, release_base=0 and one ce -> envelope=0, state=0, busy=0; gate=1 during RELEASE (release_coef=0xF00000) -> state=1 with envelope continuing from the current value.
REQ-036 SHALL verify: gate toggles and input changes with ce held 0 for 100 cycles -> envelope, state and env_valid unchanged.

Source files
------------

// File: rtl/adsr_log_env.sv
// adsr_log_env: ADSR envelope generator with exponential-style segments.
// Each ATTACK/DECAY/RELEASE step computes next = base + (env * coef) / 2^WIDTH,
// which saturates at 2^WIDTH-1. All updates happen on clk edges with ce=1.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ce                - sample tick; the envelope advances only when ce=1
//   gate              - note-on level
//   *_coef / *_base   - per-phase fractional multiplier and additive term
//   sustain_level     - level held in SUSTAIN; changes are followed live
//   envelope          - registered envelope value
//   state             - IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4
//   busy              - state != IDLE
//   env_valid         - one-cycle pulse after each ce update
module adsr_log_env #(
    parameter int unsigned      WIDTH         = 24,
    parameter logic [WIDTH-1:0] ATTACK_TARGET = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] DECAY_EPS     = WIDTH'(256),
    parameter logic [WIDTH-1:0] RELEASE_FLOOR = WIDTH'(256)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             gate,
    input  logic [WIDTH-1:0] attack_coef,
    input  logic [WIDTH-1:0] decay_coef,
    input  logic [WIDTH-1:0] release_coef,
    input  logic [WIDTH-1:0] attack_base,
    input  logic [WIDTH-1:0] decay_base,
    input  logic [WIDTH-1:0] release_base,
    input  logic [WIDTH-1:0] sustain_level,
    output logic [WIDTH-1:0] envelope,
    output logic [2:0]       state,
    output logic             busy,
    output logic             env_valid
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] env_q, env_d;
    logic             busy_q;
    logic             valid_q;

    logic [WIDTH-1:0] coef_c, base_c, step_c;
    logic [PW-1:0]    prod_c;
    logic [WIDTH:0]   sum_c;
    logic             decay_hit_c;
    state_e           atk_state_c, rel_state_c;
    logic [WIDTH-1:0] atk_env_c, rel_env_c;

    // Pick the phase whose step applies on this ce: a gate change selects the
    // phase being entered, so one multiplier serves every transition.
    always_comb begin
        coef_c = attack_coef;
        base_c = attack_base;
        case (state_q)
            S_ATTACK:  if (!gate) begin coef_c = release_coef; base_c = release_base; end
            S_DECAY:   if (gate) begin coef_c = decay_coef; base_c = decay_base; end
                       else begin coef_c = release_coef; base_c = release_base; end
            S_SUSTAIN: begin coef_c = release_coef; base_c = release_base; end
            S_RELEASE: if (!gate) begin coef_c = release_coef; base_c = release_base; end
            default:   ;
        endcase
    end

    // Shared step datapath with saturation on overflow of the WIDTH+1-bit sum.
    always_comb begin
        prod_c = PW'(env_q) * PW'(coef_c);
        sum_c  = {1'b0, base_c} + {1'b0, prod_c[PW-1:WIDTH]};
        step_c = sum_c[WIDTH] ? {WIDTH{1'b1}} : sum_c[WIDTH-1:0];
    end

    // Outcomes of an attack step and of a release step, including thresholds.
    always_comb begin
        atk_state_c = S_ATTACK;
        atk_env_c   = step_c;
        rel_state_c = S_RELEASE;
        rel_env_c   = step_c;
        if (step_c >= ATTACK_TARGET) begin
            atk_state_c = S_DECAY;
            atk_env_c   = ATTACK_TARGET;
        end
        if (step_c <= RELEASE_FLOOR) begin
            rel_state_c = S_IDLE;
            rel_env_c   = '0;
        end
        decay_hit_c = ({1'b0, step_c} <= ({1'b0, sustain_level} + (WIDTH+1)'(DECAY_EPS)));
    end

    // Next-state / next-envelope; gate changes take precedence over thresholds.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (ce) begin
            case (state_q)
                S_IDLE: begin
                    if (gate) begin
                        state_d = atk_state_c;
                        env_d   = atk_env_c;
                    end else begin
                        env_d = '0;
                    end
                end
                S_ATTACK: begin
                    if (!gate) begin
                        state_d = rel_state_c;
                        env_d   = rel_env_c;
                    end else begin
                        state_d = atk_state_c;
                        env_d   = atk_env_c;
                    end
                end
                S_DECAY: begin
                    if (!gate) begin
                        state_d = rel_state_c;
                        env_d   = rel_env_c;
                    end else if (decay_hit_c) begin
                        state_d = S_SUSTAIN;
                        env_d   = sustain_level;
                    end else begin
                        env_d = step_c;
                    end
                end
                S_SUSTAIN: begin
                    if (!gate) begin
                        state_d = rel_state_c;
                        env_d   = rel_env_c;
                    end else begin
                        env_d = sustain_level;
                    end
                end
                S_RELEASE: begin
                    if (gate) begin
                        state_d = atk_state_c;
                        env_d   = atk_env_c;
                    end else begin
                        state_d = rel_state_c;
                        env_d   = rel_env_c;
                    end
                end
                default: begin
                    // Unreachable encodings recover to a silent IDLE.
                    state_d = S_IDLE;
                    env_d   = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            env_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            busy_q  <= (state_d != S_IDLE);
            valid_q <= ce;
        end
    end

    assign envelope  = env_q;
    assign state     = state_q;
    assign busy      = busy_q;
    assign env_valid = valid_q;

endmodule

// File: tb/tb_adsr_log_env.sv
// Directed bench for adsr_log_env with hand-computed expected values.
module tb_adsr_log_env;

    localparam int unsigned WIDTH = 24;

    logic             clk = 1'b0;
    logic             rst, ce, gate;
    logic [WIDTH-1:0] attack_coef, decay_coef, release_coef;
    logic [WIDTH-1:0] attack_base, decay_base, release_base;
    logic [WIDTH-1:0] sustain_level;
    logic [WIDTH-1:0] envelope;
    logic [2:0]       state;
    logic             busy, env_valid;

    int tests  = 0;
    int failed = 0;

    adsr_log_env #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .gate          (gate),
        .attack_coef   (attack_coef),
        .decay_coef    (decay_coef),
        .release_coef  (release_coef),
        .attack_base   (attack_base),
        .decay_base    (decay_base),
        .release_base  (release_base),
        .sustain_level (sustain_level),
        .envelope      (envelope),
        .state         (state),
        .busy          (busy),
        .env_valid     (env_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One ce pulse; returns at the negedge after the updating posedge.
    task automatic step_ce();
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
    endtask

    task automatic check_es(input string tag, input logic [31:0] e, input logic [31:0] s);
        check({tag, "_env"}, 32'(envelope), e);
        check({tag, "_state"}, 32'(state), s);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; gate = 1'b0;
        attack_coef = '0; decay_coef = '0; release_coef = '0;
        attack_base = '0; decay_base = '0; release_base = '0;
        sustain_level = '0;
        repeat (2) @(negedge clk);
        check_es("reset", 32'h0, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(env_valid), 32'd0);
        rst = 1'b0;

        // Two attack steps from IDLE.
        gate = 1'b1; attack_coef = 24'd16776829; attack_base = 24'd391;
        step_ce();
        check_es("atk1", 32'd391, 32'd1);
        check("atk1_busy", 32'(busy), 32'd1);
        check("atk1_valid", 32'(env_valid), 32'd1);
        @(negedge clk);
        check("atk1_valid_drop", 32'(env_valid), 32'd0);
        step_ce();
        check_es("atk2", 32'd781, 32'd1);
        check("atk2_valid", 32'(env_valid), 32'd1);

        // Reset held two cycles mid-ATTACK, with ce active, wins.
        @(negedge clk);
        rst = 1'b1; ce = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; ce = 1'b0;
        check_es("rst_atk", 32'h0, 32'd0);
        check("rst_atk_busy", 32'(busy), 32'd0);
        check("rst_atk_valid", 32'(env_valid), 32'd0);

        // Saturating attack step ends ATTACK.
        step_ce();
        check_es("atk_again", 32'd391, 32'd1);
        attack_base = 24'hFFFFFF; attack_coef = 24'h800000;
        step_ce();
        check_es("atk_sat", 32'hFFFFFF, 32'd2);

        // DECAY: one step above threshold, then the sustain hit, then live sustain.
        decay_coef = 24'h800000; decay_base = 24'h0; sustain_level = 24'h100000;
        step_ce();
        check_es("dec_step", 32'h7FFFFF, 32'd2);
        decay_coef = 24'h0; decay_base = 24'h400000; sustain_level = 24'h400000;
        step_ce();
        check_es("dec_hit", 32'h400000, 32'd3);
        sustain_level = 24'h200000;
        step_ce();
        check_es("sus_track", 32'h200000, 32'd3);

        // Release to zero straight from SUSTAIN.
        gate = 1'b0; release_coef = 24'h0; release_base = 24'h0;
        step_ce();
        check_es("rel_zero", 32'h0, 32'd0);
        check("rel_zero_busy", 32'(busy), 32'd0);

        // Re-attack from RELEASE continues from the current envelope.
        gate = 1'b1; attack_coef = 24'h0; attack_base = 24'h100000;
        step_ce();
        check_es("atk_b", 32'h100000, 32'd1);
        gate = 1'b0; release_coef = 24'hF00000;
        step_ce();
        check_es("rel_step", 32'hF0000, 32'd4);
        check("rel_step_busy", 32'(busy), 32'd1);
        gate = 1'b1; attack_coef = 24'h800000; attack_base = 24'h10;
        step_ce();
        check_es("reattack", 32'h78010, 32'd1);

        // Release floor boundary: 257 stays, 256 ends.
        gate = 1'b0; release_coef = 24'h0; release_base = 24'h101;
        step_ce();
        check_es("floor_above", 32'h101, 32'd4);
        release_base = 24'h100;
        step_ce();
        check_es("floor_at", 32'h0, 32'd0);

        // ce held low for 100 cycles while inputs churn.
        gate = 1'b1; attack_coef = 24'h0; attack_base = 24'h1234;
        step_ce();
        check_es("hold_pre", 32'h1234, 32'd1);
        for (int i = 0; i < 100; i++) begin
            gate = ~gate;
            attack_coef = 24'($urandom); attack_base = 24'($urandom);
            release_coef = 24'($urandom); release_base = 24'($urandom);
            sustain_level = 24'($urandom);
            @(negedge clk);
            check_es("hold", 32'h1234, 32'd1);
            check("hold_valid", 32'(env_valid), 32'd0);
        end

        // Gate release beats a saturating attack on the same ce.
        gate = 1'b0; attack_coef = 24'h800000; attack_base = 24'hFFFFFF;
        release_coef = 24'h0; release_base = 24'h500;
        step_ce();
        check_es("gate_prio", 32'h500, 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
